// File: rtl/mem_port_bridge_if.sv
// rtl/mem_port_bridge_if.sv - arbiter-side port bundle of mem_port_bridge
//   req_o/ack_i        held request / grant-in-cycle handshake
//   adr_o/dat_o/dm_o   23-bit word address, replicated write data, byte mask (1=masked)
//   rd_o/wr_o          operation qualifiers, exactly one high while req_o=1
//   valid_i/rdat_i     read data return
//   master: bridge side, slave: arbiter side
interface mem_port_bridge_if;
    logic        req_o;
    logic        ack_i;
    logic [22:0] adr_o;
    logic [15:0] dat_o;
    logic [1:0]  dm_o;
    logic        rd_o;
    logic        wr_o;
    logic        valid_i;
    logic [15:0] rdat_i;

    modport master (
        output req_o, adr_o, dat_o, dm_o, rd_o, wr_o,
        input  ack_i, valid_i, rdat_i
    );

    modport slave (
        input  req_o, adr_o, dat_o, dm_o, rd_o, wr_o,
        output ack_i, valid_i, rdat_i
    );
endinterface

// File: rtl/mem_port_bridge.sv
// rtl/mem_port_bridge.sv - byte-wide client front end for one memory arbiter port
//   clock_i, reset_n_i          clock, asynchronous active-low reset
//   cpu_req_i/cpu_wr_i          one-cycle strobe and direction, ignored while cpu_busy_o=1
//   cpu_adr_i/cpu_dat_i         byte address and write data
//   cpu_dat_o/cpu_rvalid_o      read data (held) and one-cycle update pulse
//   cpu_busy_o                  write FIFO full or read pending
//   mem                         arbiter handshake (mem_port_bridge_if.master)
module mem_port_bridge #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              cpu_req_i,
    input  logic              cpu_wr_i,
    input  logic [23:0]       cpu_adr_i,
    input  logic [7:0]        cpu_dat_i,
    output logic [7:0]        cpu_dat_o,
    output logic              cpu_rvalid_o,
    output logic              cpu_busy_o,
    mem_port_bridge_if.master mem
);
    localparam int              AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     L_DEPTH = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_REQ_W, S_REQ_R, S_CYC_W, S_CYC_R} state_t;

    state_t      r_state, w_state_nxt;
    logic [23:0] r_fifo_adr [FIFO_DEPTH];
    logic [7:0]  r_fifo_dat [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic        r_rd_pend, r_busy;
    logic [23:0] r_rd_adr;
    logic        r_req, r_rd, r_wr, r_got, r_rvalid;
    logic [22:0] r_adr;
    logic [15:0] r_dat;
    logic [1:0]  r_dm;
    logic [7:0]  r_cap, r_cpu_dat;

    logic        w_accept, w_push, w_rd_strobe, w_pop, w_rd_done, w_empty, w_pend_nxt;
    logic [AW:0] w_count_nxt;
    logic [23:0] w_head_adr;
    logic [7:0]  w_head_dat;
    logic        w_req_nxt, w_rd_nxt, w_wr_nxt, w_got_nxt, w_rvalid_nxt;
    logic [22:0] w_adr_nxt;
    logic [15:0] w_dat_nxt;
    logic [1:0]  w_dm_nxt;
    logic [7:0]  w_cap_nxt, w_cpu_dat_nxt;

    assign w_accept    = cpu_req_i & ~r_busy;
    assign w_push      = w_accept & cpu_wr_i;
    assign w_rd_strobe = w_accept & ~cpu_wr_i;
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_head_adr  = r_fifo_adr[r_rd_ptr[AW-1:0]];
    assign w_head_dat  = r_fifo_dat[r_rd_ptr[AW-1:0]];

    // Busy is computed from the post-edge occupancy so it already covers the
    // strobe being accepted on this edge.
    assign w_count_nxt = r_wr_ptr - r_rd_ptr + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign w_pend_nxt  = w_rd_strobe | (r_rd_pend & ~w_rd_done);

    always_ff @(posedge clock_i) begin
        if (w_push) begin
            r_fifo_adr[r_wr_ptr[AW-1:0]] <= cpu_adr_i;
            r_fifo_dat[r_wr_ptr[AW-1:0]] <= cpu_dat_i;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_pend <= 1'b0;
            r_rd_adr  <= '0;
            r_busy    <= 1'b0;
        end else begin
            if (w_push)      r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)       r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_rd_strobe) r_rd_adr <= cpu_adr_i;
            r_rd_pend <= w_pend_nxt;
            r_busy    <= (w_count_nxt == L_DEPTH) | w_pend_nxt;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= S_IDLE;
            r_req     <= 1'b0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_dm      <= '0;
            r_got     <= 1'b0;
            r_cap     <= '0;
            r_cpu_dat <= 8'hFF;
            r_rvalid  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_req     <= w_req_nxt;
            r_rd      <= w_rd_nxt;
            r_wr      <= w_wr_nxt;
            r_adr     <= w_adr_nxt;
            r_dat     <= w_dat_nxt;
            r_dm      <= w_dm_nxt;
            r_got     <= w_got_nxt;
            r_cap     <= w_cap_nxt;
            r_cpu_dat <= w_cpu_dat_nxt;
            r_rvalid  <= w_rvalid_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_req_nxt     = r_req;
        w_rd_nxt      = r_rd;
        w_wr_nxt      = r_wr;
        w_adr_nxt     = r_adr;
        w_dat_nxt     = r_dat;
        w_dm_nxt      = r_dm;
        w_got_nxt     = r_got;
        w_cap_nxt     = r_cap;
        w_cpu_dat_nxt = r_cpu_dat;
        w_rvalid_nxt  = 1'b0;
        w_pop         = 1'b0;
        w_rd_done     = 1'b0;
        case (r_state)
            // Queued writes always go first so a read sees every earlier write.
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = S_REQ_W;
                    w_req_nxt   = 1'b1;
                    w_wr_nxt    = 1'b1;
                    w_adr_nxt   = w_head_adr[23:1];
                    w_dat_nxt   = {w_head_dat, w_head_dat};
                    w_dm_nxt    = w_head_adr[0] ? 2'b01 : 2'b10;
                end else if (r_rd_pend) begin
                    w_state_nxt = S_REQ_R;
                    w_req_nxt   = 1'b1;
                    w_rd_nxt    = 1'b1;
                    w_adr_nxt   = r_rd_adr[23:1];
                    w_dm_nxt    = 2'b00;
                    w_got_nxt   = 1'b0;
                end
            end
            S_REQ_W: if (mem.ack_i) w_state_nxt = S_CYC_W;
            S_REQ_R: if (mem.ack_i) w_state_nxt = S_CYC_R;
            S_CYC_W: begin
                if (!mem.ack_i) begin
                    w_state_nxt = S_IDLE;
                    w_pop       = 1'b1;
                    w_req_nxt   = 1'b0;
                    w_wr_nxt    = 1'b0;
                end
            end
            S_CYC_R: begin
                if (!mem.ack_i) begin
                    // No data seen during the cycle returns all-ones.
                    w_state_nxt   = S_IDLE;
                    w_rd_done     = 1'b1;
                    w_req_nxt     = 1'b0;
                    w_rd_nxt      = 1'b0;
                    w_cpu_dat_nxt = r_got ? r_cap : 8'hFF;
                    w_rvalid_nxt  = 1'b1;
                end else if (mem.valid_i && !r_got) begin
                    w_got_nxt = 1'b1;
                    w_cap_nxt = r_rd_adr[0] ? mem.rdat_i[15:8] : mem.rdat_i[7:0];
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign mem.req_o    = r_req;
    assign mem.rd_o     = r_rd;
    assign mem.wr_o     = r_wr;
    assign mem.adr_o    = r_adr;
    assign mem.dat_o    = r_dat;
    assign mem.dm_o     = r_dm;
    assign cpu_dat_o    = r_cpu_dat;
    assign cpu_rvalid_o = r_rvalid;
    assign cpu_busy_o   = r_busy;
endmodule

// File: tb/tb_mem_port_bridge.sv
// tb/tb_mem_port_bridge.sv - self-checking bench for mem_port_bridge
`timescale 1ns/1ps
module tb_mem_port_bridge;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_wr;
    logic [23:0] cpu_adr;
    logic [7:0]  cpu_dat, dut_dat;
    logic        rvalid, busy;

    always #5 clk = ~clk;

    mem_port_bridge_if bus ();

    mem_port_bridge #(.FIFO_DEPTH(4)) dut (
        .clock_i      (clk),
        .reset_n_i    (rst_n),
        .cpu_req_i    (cpu_req),
        .cpu_wr_i     (cpu_wr),
        .cpu_adr_i    (cpu_adr),
        .cpu_dat_i    (cpu_dat),
        .cpu_dat_o    (dut_dat),
        .cpu_rvalid_o (rvalid),
        .cpu_busy_o   (busy),
        .mem          (bus)
    );

    int checks = 0;
    int errors = 0;
    int rv_cnt = 0;
    bit resp_en = 0;
    int nodata_pct = 0;

    typedef struct packed {
        logic        is_wr;
        logic [23:0] adr;
        logic [7:0]  dat;
    } op_t;

    logic [7:0]  ref_mem [int];
    logic [15:0] bus_mem [int];
    op_t         exp_q [$];

    function automatic logic [7:0] dflt(input int a);
        return 8'(a ^ (a >> 8) ^ 32'h3C);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [23:0] a);
        int k;
        k = int'(a);
        if (ref_mem.exists(k)) return ref_mem[k];
        return dflt(k);
    endfunction

    function automatic logic [15:0] bus_word(input int w);
        if (bus_mem.exists(w)) return bus_mem[w];
        return {dflt(2*w+1), dflt(2*w)};
    endfunction

    initial forever begin
        @(negedge clk);
        if (rvalid === 1'b1) rv_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Arbiter + memory model with an order scoreboard for the randomized tests.
    initial begin : responder
        op_t         e;
        logic [22:0] s_adr;
        logic [15:0] s_dat, w;
        logic [1:0]  s_dm, e_dm;
        logic        s_rd, s_wr;
        logic [7:0]  want;
        int          dly, len, vk;
        bit          nod, stable;
        bus.ack_i = 0; bus.valid_i = 0; bus.rdat_i = 0;
        forever begin
            @(negedge clk);
            if (resp_en && rst_n && bus.req_o === 1'b1) begin
                dly = $urandom_range(0, 3);
                repeat (dly) @(negedge clk);
                s_adr = bus.adr_o; s_dat = bus.dat_o; s_dm = bus.dm_o;
                s_rd = bus.rd_o; s_wr = bus.wr_o;
                e = '0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_op adr=%h wr=%b required=no_op", s_adr, s_wr);
                end else begin
                    e = exp_q.pop_front();
                    e_dm = e.is_wr ? (e.adr[0] ? 2'b01 : 2'b10) : 2'b00;
                    if (s_wr !== e.is_wr || s_rd !== !e.is_wr || s_adr !== e.adr[23:1] ||
                        s_dm !== e_dm || (e.is_wr && s_dat !== {e.dat, e.dat})) begin
                        errors++;
                        $display("FAIL sb_op got wr=%b rd=%b adr=%h dat=%h dm=%b required wr=%b adr=%h dat=%h dm=%b",
                                 s_wr, s_rd, s_adr, s_dat, s_dm, e.is_wr, e.adr[23:1], {e.dat, e.dat}, e_dm);
                    end
                end
                nod = s_rd && ($urandom_range(0, 99) < nodata_pct);
                len = s_rd ? $urandom_range(2, 4) : $urandom_range(1, 3);
                vk  = s_rd ? $urandom_range(1, len - 1) : 0;
                stable = 1;
                bus.ack_i = 1;
                for (int k = 0; k < len; k++) begin
                    bus.valid_i = s_rd && !nod && (k == vk);
                    bus.rdat_i  = bus.valid_i ? bus_word(int'(s_adr)) : 16'($urandom);
                    @(negedge clk);
                    if (bus.req_o !== 1'b1 || bus.adr_o !== s_adr || bus.dat_o !== s_dat ||
                        bus.dm_o !== s_dm || bus.rd_o !== s_rd || bus.wr_o !== s_wr) stable = 0;
                end
                bus.ack_i = 0; bus.valid_i = 0;
                checks++;
                if (!stable) begin
                    errors++;
                    $display("FAIL sb_stable outputs changed during cycle adr=%h required=held", s_adr);
                end
                if (s_wr) begin
                    w = bus_word(int'(s_adr));
                    if (!s_dm[0]) w[7:0]  = s_dat[7:0];
                    if (!s_dm[1]) w[15:8] = s_dat[15:8];
                    bus_mem[int'(s_adr)] = w;
                end
                @(negedge clk);
                checks++;
                if (bus.req_o !== 1'b0 || bus.rd_o !== 1'b0 || bus.wr_o !== 1'b0) begin
                    errors++;
                    $display("FAIL sb_release req=%b rd=%b wr=%b required 0 0 0", bus.req_o, bus.rd_o, bus.wr_o);
                end
                if (s_rd) begin
                    want = nod ? 8'hFF : e.dat;
                    checks++;
                    if (rvalid !== 1'b1 || dut_dat !== want) begin
                        errors++;
                        $display("FAIL sb_rdata rvalid=%b dat=%h required rvalid=1 dat=%h", rvalid, dut_dat, want);
                    end
                end
            end
        end
    end

    task automatic strobe(input bit wr, input logic [23:0] a, input logic [7:0] d);
        cpu_req = 1; cpu_wr = wr; cpu_adr = a; cpu_dat = d;
        @(negedge clk);
        cpu_req = 0;
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (busy === 1'b1 && t < 300) begin @(negedge clk); t++; end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_timeout busy=%b required=0", tag, busy);
        end
    endtask

    task automatic issue(input bit wr, input logic [23:0] a, input logic [7:0] d);
        wait_idle("issue");
        if (wr) begin
            ref_mem[int'(a)] = d;
            exp_q.push_back({1'b1, a, d});
        end else begin
            exp_q.push_back({1'b0, a, ref_rd(a)});
        end
        strobe(wr, a, d);
    endtask

    task automatic arb_cycle(input int len, input int vk, input logic [15:0] rd,
                             output logic [22:0] a, output logic [15:0] d, output logic ok);
        int t;
        t = 0;
        while (bus.req_o !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        ok = (bus.req_o === 1'b1);
        a = bus.adr_o; d = bus.dat_o;
        if (ok) begin
            bus.ack_i = 1;
            for (int k = 0; k < len; k++) begin
                bus.valid_i = (k == vk);
                bus.rdat_i  = (k == vk) ? rd : 16'h0000;
                @(negedge clk);
            end
            bus.ack_i = 0; bus.valid_i = 0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 0; cpu_req = 0; cpu_wr = 0; cpu_adr = 0; cpu_dat = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.req_o, bus.rd_o, bus.wr_o, rvalid, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl req/rd/wr/rvalid/busy=%b required=00000", {bus.req_o, bus.rd_o, bus.wr_o, rvalid, busy});
        end
        checks++;
        if ({bus.adr_o, bus.dat_o, bus.dm_o} !== 41'b0) begin
            errors++;
            $display("FAIL reset_bus adr=%h dat=%h dm=%b required all 0", bus.adr_o, bus.dat_o, bus.dm_o);
        end
        checks++;
        if (dut_dat !== 8'hFF) begin
            errors++;
            $display("FAIL reset_rdata dat=%h required=ff", dut_dat);
        end
        rst_n = 1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.req_o !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release req=%b busy=%b required 0 0", bus.req_o, busy);
        end
    endtask

    task automatic test_single_write;
        strobe(1, 24'h000101, 8'h5A);
        checks++;
        if (bus.req_o !== 1'b0) begin
            errors++;
            $display("FAIL sw_latency1 req=%b required=0", bus.req_o);
        end
        @(negedge clk);
        checks++;
        if (bus.req_o !== 1'b1 || bus.wr_o !== 1'b1 || bus.rd_o !== 1'b0 || bus.adr_o !== 23'h000080 ||
            bus.dat_o !== 16'h5A5A || bus.dm_o !== 2'b01) begin
            errors++;
            $display("FAIL sw_fields req=%b wr=%b rd=%b adr=%h dat=%h dm=%b required 1 1 0 000080 5a5a 01",
                     bus.req_o, bus.wr_o, bus.rd_o, bus.adr_o, bus.dat_o, bus.dm_o);
        end
        bus.ack_i = 1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.req_o !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sw_hold req=%b busy=%b required 1 0", bus.req_o, busy);
        end
        bus.ack_i = 0;
        @(negedge clk);
        checks++;
        if (bus.req_o !== 1'b0 || bus.wr_o !== 1'b0) begin
            errors++;
            $display("FAIL sw_drop req=%b wr=%b required 0 0", bus.req_o, bus.wr_o);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read_odd;
        int rv0;
        logic [22:0] a; logic [15:0] d; logic ok;
        rv0 = rv_cnt;
        strobe(0, 24'h000203, 8'h00);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rd_busy busy=%b required=1", busy);
        end
        @(negedge clk);
        checks++;
        if (bus.req_o !== 1'b1 || bus.rd_o !== 1'b1 || bus.wr_o !== 1'b0 || bus.adr_o !== 23'h000101 || bus.dm_o !== 2'b00) begin
            errors++;
            $display("FAIL rd_fields req=%b rd=%b wr=%b adr=%h dm=%b required 1 1 0 000101 00",
                     bus.req_o, bus.rd_o, bus.wr_o, bus.adr_o, bus.dm_o);
        end
        arb_cycle(3, 1, 16'hBEEF, a, d, ok);
        checks++;
        if (!ok || rvalid !== 1'b1 || dut_dat !== 8'hBE || bus.req_o !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rd_done ok=%b rvalid=%b dat=%h req=%b busy=%b required 1 1 be 0 0", ok, rvalid, dut_dat, bus.req_o, busy);
        end
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0 || dut_dat !== 8'hBE) begin
            errors++;
            $display("FAIL rd_hold rvalid=%b dat=%h required 0 be", rvalid, dut_dat);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (rv_cnt - rv0 != 1) begin
            errors++;
            $display("FAIL rd_pulses count=%0d required=1", rv_cnt - rv0);
        end
    endtask

    task automatic test_missing_data;
        int rv0;
        logic [22:0] a; logic [15:0] d; logic ok;
        rv0 = rv_cnt;
        strobe(0, 24'h000455, 8'h00);
        arb_cycle(2, -1, 16'h0000, a, d, ok);
        checks++;
        if (!ok || rvalid !== 1'b1 || dut_dat !== 8'hFF) begin
            errors++;
            $display("FAIL nd_data ok=%b rvalid=%b dat=%h required 1 1 ff", ok, rvalid, dut_dat);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (rv_cnt - rv0 != 1 || bus.req_o !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL nd_idle pulses=%0d req=%b busy=%b required 1 0 0", rv_cnt - rv0, bus.req_o, busy);
        end
    endtask

    task automatic test_fifo_full;
        logic [23:0] adrs [4];
        logic [7:0]  dats [4];
        logic [22:0] a; logic [15:0] d; logic ok;
        bit extra;
        for (int i = 0; i < 4; i++) begin
            adrs[i] = 24'h100000 | 24'($urandom_range(0, 16'hFFFF)) | 24'(i << 16);
            dats[i] = 8'($urandom);
        end
        for (int i = 0; i < 4; i++) begin
            cpu_req = 1; cpu_wr = 1; cpu_adr = adrs[i]; cpu_dat = dats[i];
            @(negedge clk);
            if (i == 2) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL ff_early busy=%b required=0", busy);
                end
            end
        end
        cpu_req = 0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL ff_full busy=%b required=1", busy);
        end
        strobe(1, 24'h0FFFFF, 8'hEE);
        for (int i = 0; i < 4; i++) begin
            arb_cycle(1, -1, 16'h0000, a, d, ok);
            checks++;
            if (!ok || a !== adrs[i][23:1] || d !== {dats[i], dats[i]}) begin
                errors++;
                $display("FAIL ff_order%0d ok=%b adr=%h dat=%h required adr=%h dat=%h", i, ok, a, d, adrs[i][23:1], {dats[i], dats[i]});
            end
            if (i == 0) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL ff_unbusy busy=%b required=0", busy);
                end
            end
        end
        extra = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (bus.req_o !== 1'b0) extra = 1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL ff_dropped_strobe req_seen=1 required=0");
        end
    endtask

    task automatic test_reset_mid_cycle;
        int t;
        bit seen;
        cpu_req = 1; cpu_wr = 1; cpu_adr = 24'h020001; cpu_dat = 8'h11;
        @(negedge clk);
        cpu_adr = 24'h020002; cpu_dat = 8'h22;
        @(negedge clk);
        cpu_req = 0;
        t = 0;
        while (bus.req_o !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        bus.ack_i = 1;
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        checks++;
        if ({bus.req_o, bus.wr_o, bus.rd_o, busy, rvalid} !== 5'b0 || {bus.adr_o, bus.dat_o, bus.dm_o} !== 41'b0 || dut_dat !== 8'hFF) begin
            errors++;
            $display("FAIL rst_async req=%b wr=%b busy=%b adr=%h dat=%h dm=%b rdata=%h required all 0 rdata=ff",
                     bus.req_o, bus.wr_o, busy, bus.adr_o, bus.dat_o, bus.dm_o, dut_dat);
        end
        bus.ack_i = 0;
        @(negedge clk);
        rst_n = 1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.req_o !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_no_req req_seen=1 required=0");
        end
    endtask

    task automatic test_ordering;
        logic [23:0] base;
        int t;
        bit seen, held;
        resp_en = 1; nodata_pct = 0;
        base = 24'h300000 | 24'($urandom_range(0, 16'hFFF0));
        for (int i = 0; i < 3; i++) issue(1, base + 24'(i), 8'($urandom));
        wait_idle("ord_read");
        exp_q.push_back({1'b0, base + 24'd1, ref_rd(base + 24'd1)});
        strobe(0, base + 24'd1, 8'h00);
        t = 0; seen = 0; held = 1;
        while (!seen && t < 300) begin
            if (rvalid === 1'b1) begin
                seen = 1;
                if (busy !== 1'b0) held = 0;
            end else begin
                if (busy !== 1'b1) held = 0;
                @(negedge clk);
                t++;
            end
        end
        checks++;
        if (!seen || !held) begin
            errors++;
            $display("FAIL ord_busy rvalid_seen=%b busy_held=%b required 1 1", seen, held);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL ord_drain pending=%0d required=0", exp_q.size());
        end
        resp_en = 0;
    endtask

    task automatic test_random;
        logic [23:0] a;
        int t;
        resp_en = 1; nodata_pct = 20;
        for (int n = 0; n < 80; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (busy === 1'b1 && $urandom_range(0, 3) == 0)
                strobe($urandom_range(0, 1) == 1, 24'h0FFFF0, 8'hC3);
            a = 24'h5A3C00 | 24'($urandom_range(0, 15));
            issue($urandom_range(0, 1) == 1, a, 8'($urandom));
        end
        t = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && t < 500) begin @(negedge clk); t++; end
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain pending=%0d busy=%b required 0 0", exp_q.size(), busy);
        end
        resp_en = 0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_odd();
        test_missing_data();
        test_fifo_full();
        test_reset_mid_cycle();
        test_ordering();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
